// File: rtl/man_input_arb_pkg.sv
// Shared types and constants for the ManInput AXI4-Lite arbiter.
package man_input_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG0 = 4'h0;
  localparam logic [3:0] REG1 = 4'h4;
  localparam logic [3:0] REG2 = 4'h8;
  localparam logic [3:0] REG3 = 4'hC;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr, first set request wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      k = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!any && req[k]) begin
        any    = 1'b1;
        idx    = k;
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/man_input_axil_arbiter.sv
// Serialises single-word commands from NUM_REQ requesters onto one AXI4-Lite master.
// Define MAN_INPUT_ARB_TIMEOUT_EN to add the wait-state watchdog and timeout_flag port.
module man_input_axil_arbiter
  import man_input_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_W-1:0]         M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_W-1:0]         M_AXI_WDATA,
  output logic [DATA_W/8-1:0]       M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_W-1:0]         M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_W-1:0]         M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
`ifdef MAN_INPUT_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_flag
`endif
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("man_input_axil_arbiter: unsupported parameter set");
  end

  arb_state_t state, state_d;

  logic [IDX_W-1:0]                rr_ptr, cur_idx, g_idx;
  logic [NUM_REQ-1:0]              gnt;
  logic                            g_any;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata_v;
  logic [ADDR_W-1:0]               cur_addr;
  logic [DATA_W-1:0]               cur_wdata, rdata_q;
  logic [1:0]                      resp_q;
  logic                            aw_done, w_done, aw_fire, w_fire, tmo_hit;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (g_idx),
    .any (g_any)
  );

  // Reset gating keeps the combinational grant quiet while ARESETN is low.
  assign req_ready = (ARESETN && state == ST_IDLE) ? gnt : '0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_valid[i] = (state == ST_RSP) && (cur_idx == IDX_W'(i));
  end
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  assign M_AXI_AWADDR  = cur_addr;
  assign M_AXI_ARADDR  = cur_addr;
  assign M_AXI_WDATA   = cur_wdata;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = (state == ST_WR) && !aw_done;
  assign M_AXI_WVALID  = (state == ST_WR) && !w_done;
  assign M_AXI_WSTRB   = (state == ST_WR) ? {(DATA_W/8){1'b1}} : '0;
  assign M_AXI_BREADY  = (state == ST_WR_RESP);
  assign M_AXI_ARVALID = (state == ST_RD_ADDR);
  assign M_AXI_RREADY  = (state == ST_RD_DATA);

  assign aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire  = M_AXI_WVALID && M_AXI_WREADY;

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (g_any) state_d = req_write[g_idx] ? ST_WR : ST_RD_ADDR;
      ST_WR:      if ((aw_done || aw_fire) && (w_done || w_fire)) state_d = ST_WR_RESP;
      ST_WR_RESP: if (M_AXI_BVALID) state_d = ST_RSP;
      ST_RD_ADDR: if (M_AXI_ARREADY) state_d = ST_RD_DATA;
      ST_RD_DATA: if (M_AXI_RVALID) state_d = ST_RSP;
      ST_RSP:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (tmo_hit) state_d = ST_RSP;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= ST_IDLE;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      cur_idx   <= '0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state <= state_d;
      if (tmo_hit) begin
        rdata_q <= '0;
        resp_q  <= RESP_SLVERR;
      end else begin
        case (state)
          ST_IDLE: if (g_any) begin
            cur_idx   <= g_idx;
            rr_ptr    <= g_idx;
            cur_addr  <= addr_v[g_idx];
            cur_wdata <= wdata_v[g_idx];
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
          end
          ST_WR: begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
          end
          ST_WR_RESP: if (M_AXI_BVALID) begin
            rdata_q <= '0;
            resp_q  <= M_AXI_BRESP;
          end
          ST_RD_DATA: if (M_AXI_RVALID) begin
            rdata_q <= M_AXI_RDATA;
            resp_q  <= M_AXI_RRESP;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MAN_INPUT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             waiting;

  assign waiting = state inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA};
  // The entry cycle counts as cycle 1, so the limit fires in cycle TIMEOUT_CYCLES.
  assign tmo_hit = waiting && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tmo_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state_d != state) tmo_cnt <= '0;
      else if (waiting)     tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (tmo_hit) timeout_flag <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_man_input_axil_arbiter.sv
// Directed bench for man_input_axil_arbiter with a 4-register AXI4-Lite slave model.
module tb_man_input_axil_arbiter;
  import man_input_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;

  logic                            ACLK, ARESETN;
  logic [NUM_REQ-1:0]              req_valid, req_write, req_ready, rsp_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  t_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0]  t_wdata;
  logic [DATA_W-1:0]               rsp_rdata;
  logic [1:0]                      rsp_resp;
  logic [ADDR_W-1:0]               M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]                      M_AXI_AWPROT, M_AXI_ARPROT;
  logic                            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [DATA_W-1:0]               M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]                      M_AXI_WSTRB;
  logic [1:0]                      M_AXI_BRESP, M_AXI_RRESP;
  logic                            M_AXI_BVALID, M_AXI_BREADY;
  logic                            M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
`ifdef MAN_INPUT_ARB_TIMEOUT_EN
  logic                            timeout_flag;
`endif

  man_input_axil_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(t_addr), .req_wdata(t_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
`ifdef MAN_INPUT_ARB_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Slave model: configurable ready delays, optional RRESP error on 0x8, optional missing B.
  logic [31:0] mem [4] = '{default: 32'h0};
  logic        aw_got, w_got, b_pend, r_pend;
  logic [3:0]  aw_a, r_a, aw_cur;
  logic [31:0] w_d, w_cur;
  int          aw_n, w_n, r_n, bhs_cnt;
  int          aw_wait = 0, w_wait = 0, r_wait = 0;
  bit          err8 = 1'b0, no_b = 1'b0;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_n >= aw_wait);
  assign M_AXI_WREADY  = M_AXI_WVALID && (w_n >= w_wait);
  assign M_AXI_BVALID  = b_pend && !no_b;
  assign M_AXI_BRESP   = 2'b00;
  assign M_AXI_ARREADY = M_AXI_ARVALID;
  assign M_AXI_RVALID  = r_pend && (r_n >= r_wait);
  assign M_AXI_RDATA   = M_AXI_RVALID ? mem[r_a[3:2]] : 32'h0;
  assign M_AXI_RRESP   = (M_AXI_RVALID && err8 && r_a == 4'h8) ? 2'b10 : 2'b00;
  assign aw_cur        = (M_AXI_AWVALID && M_AXI_AWREADY) ? M_AXI_AWADDR : aw_a;
  assign w_cur         = (M_AXI_WVALID && M_AXI_WREADY) ? M_AXI_WDATA : w_d;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_a <= '0; r_a <= '0; w_d <= '0;
      aw_n <= 0; w_n <= 0; r_n <= 0; bhs_cnt <= bhs_cnt;
    end else begin
      aw_n <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_n + 1 : 0;
      w_n  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_n + 1 : 0;
      r_n  <= (r_pend && !M_AXI_RVALID) ? r_n + 1 : 0;
      if ((aw_got || (M_AXI_AWVALID && M_AXI_AWREADY)) && (w_got || (M_AXI_WVALID && M_AXI_WREADY))) begin
        mem[aw_cur[3:2]] <= w_cur;
        b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_got <= 1'b1; aw_a <= M_AXI_AWADDR; end
        if (M_AXI_WVALID && M_AXI_WREADY)   begin w_got <= 1'b1;  w_d <= M_AXI_WDATA; end
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin b_pend <= 1'b0; bhs_cnt <= bhs_cnt + 1; end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin r_pend <= 1'b1; r_a <= M_AXI_ARADDR; end
      if (M_AXI_RVALID && M_AXI_RREADY) r_pend <= 1'b0;
    end
  end

  // Monitor sampled away from the active edge.
  int awv_cyc = 0, wv_cyc = 0, rsp_cnt = 0;
  int gnt_idx[$];
  int gnt_cyc[$];
  always @(negedge ACLK) begin
    if (M_AXI_AWVALID) awv_cyc <= awv_cyc + 1;
    if (M_AXI_WVALID)  wv_cyc  <= wv_cyc + 1;
    if (rsp_valid != '0) rsp_cnt <= rsp_cnt + 1;
    if (req_ready != '0) begin
      gnt_idx.push_back(req_ready[1] ? 1 : 0);
      gnt_cyc.push_back(cyc);
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One command from requester r; returns response and grant-to-rsp_valid latency.
  task automatic issue(input bit r, input bit wr, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic [1:0] rr, output int lat,
                       output bit stray, output bit ok);
    int n;
    ok = 1'b0; stray = 1'b0; rd = '0; rr = '0; lat = 0;
    t_addr[r] = a; t_wdata[r] = d; req_write[r] = wr; req_valid[r] = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge ACLK);
      if (req_ready[r]) break;
    end
    @(posedge ACLK); #1;
    req_valid[r] = 1'b0;
    if (n == 40) return;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge ACLK);
      if (rsp_valid != '0) begin
        if (rsp_valid != (2'b01 << r)) stray = 1'b1;
        rd = rsp_rdata; rr = rsp_resp; ok = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    bit          r;
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    bit          err8;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    int          lat, base, a0, w0, b0, r0, rc, n;
    bit          stray, ok;

    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    int          lat, base, a0, w0, b0, r0, rc, n;
    bit          stray, ok;

    tbl[0] = '{1'b0, 1'b1, REG0, 32'h0000_0001, 1'b0, 32'h0, RESP_OKAY, 3};
    tbl[1] = '{1'b0, 1'b1, REG1, 32'h0000_0002, 1'b0, 32'h0, RESP_OKAY, 3};
    tbl[2] = '{1'b0, 1'b1, REG2, 32'h0000_0003, 1'b0, 32'h0, RESP_OKAY, 3};
    tbl[3] = '{1'b0, 1'b1, REG3, 32'h0000_0004, 1'b0, 32'h0, RESP_OKAY, 3};
    tbl[4] = '{1'b0, 1'b0, REG0, 32'h0, 1'b0, 32'h0000_0001, RESP_OKAY, 3};
    tbl[5] = '{1'b0, 1'b0, REG1, 32'h0, 1'b0, 32'h0000_0002, RESP_OKAY, 3};
    tbl[6] = '{1'b0, 1'b0, REG2, 32'h0, 1'b0, 32'h0000_0003, RESP_OKAY, 3};
    tbl[7] = '{1'b0, 1'b0, REG3, 32'h0, 1'b0, 32'h0000_0004, RESP_OKAY, 3};
    // Slave errors the 0x8 read: data still forwarded, SLVERR only to requester 1.
    tbl[8] = '{1'b1, 1'b0, REG2, 32'h0, 1'b1, 32'h0000_0003, RESP_SLVERR, 3};

    ARESETN = 1'b0; req_valid = '0; req_write = '0; t_addr = '0; t_wdata = '0;
    repeat (2) @(posedge ACLK);
    #1 req_valid = 2'b11;
    @(negedge ACLK);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_axi_handshakes", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'h0);
    chk("rst_awaddr", 32'(M_AXI_AWADDR), 32'h0);
    chk("rst_wstrb", 32'(M_AXI_WSTRB), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_resp", 32'(rsp_resp), 32'h0);
`ifdef MAN_INPUT_ARB_TIMEOUT_EN
    chk("rst_timeout_flag", 32'(timeout_flag), 32'h0);
`endif
    req_valid = '0;
    @(negedge ACLK) ARESETN = 1'b1;
    @(posedge ACLK); #1;

    foreach (tbl[i]) begin
      err8 = tbl[i].err8;
      issue(tbl[i].r, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, rr, lat, stray, ok);
      chk($sformatf("v%0d_done", i), 32'(ok), 32'h1);
      if (ok) begin
        chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
        chk($sformatf("v%0d_resp", i), 32'(rr), 32'(tbl[i].exp_resp));
        chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
        chk($sformatf("v%0d_stray_rsp", i), 32'(stray), 32'h0);
      end
      err8 = 1'b0;
      @(posedge ACLK); #1;
    end

    // Both requesters hold req_valid; grants must alternate 0,1,0,1 every 4 cycles.
    base = gnt_idx.size();
    t_addr[0] = REG0; t_addr[1] = REG1; req_write = '0; req_valid = 2'b11;
    for (n = 0; n < 60 && gnt_idx.size() < base + 4; n++) @(posedge ACLK);
    #1 req_valid = '0;
    repeat (6) @(posedge ACLK);
    chk("alt_grant_count", 32'(gnt_idx.size() - base), 32'd4);
    if (gnt_idx.size() >= base + 4) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("alt_grant%0d_idx", k), 32'(gnt_idx[base+k]), 32'(k % 2));
      for (int k = 1; k < 4; k++)
        chk($sformatf("alt_grant%0d_interval", k), 32'(gnt_cyc[base+k] - gnt_cyc[base+k-1]), 32'd4);
    end
    #1;

    // AWREADY arrives in the 3rd AWVALID cycle, WREADY immediately.
    aw_wait = 2;
    a0 = awv_cyc; w0 = wv_cyc; b0 = bhs_cnt; r0 = rsp_cnt;
    issue(1'b0, 1'b1, REG3, 32'hA5A5_0001, rd, rr, lat, stray, ok);
    repeat (3) @(negedge ACLK);
    chk("awdly_done", 32'(ok), 32'h1);
    chk("awdly_awvalid_cycles", 32'(awv_cyc - a0), 32'd3);
    chk("awdly_wvalid_cycles", 32'(wv_cyc - w0), 32'd1);
    chk("awdly_b_handshakes", 32'(bhs_cnt - b0), 32'd1);
    chk("awdly_rsp_count", 32'(rsp_cnt - r0), 32'd1);
    chk("awdly_latency", 32'(lat), 32'd5);
    chk("awdly_resp", 32'(rr), 32'(RESP_OKAY));
    aw_wait = 0;
    @(posedge ACLK); #1;
    issue(1'b0, 1'b0, REG3, 32'h0, rd, rr, lat, stray, ok);
    chk("awdly_readback", rd, 32'hA5A5_0001);
    @(posedge ACLK); #1;

    // Reset while parked in RD_DATA (slave withholds RVALID).
    r_wait = 1000;
    t_addr[0] = REG1; req_write[0] = 1'b0; req_valid[0] = 1'b1;
    for (n = 0; n < 20 && !req_ready[0]; n++) @(negedge ACLK);
    @(posedge ACLK); #1 req_valid[0] = 1'b0;
    for (n = 0; n < 20 && !M_AXI_RREADY; n++) @(negedge ACLK);
    chk("rstmid_reached_rd_data", 32'(M_AXI_RREADY), 32'h1);
    rc = rsp_cnt;
    @(posedge ACLK); #2 ARESETN = 1'b0;
    #1;
    chk("rstmid_arvalid_low", 32'(M_AXI_ARVALID), 32'h0);
    chk("rstmid_rready_low", 32'(M_AXI_RREADY), 32'h0);
    @(negedge ACLK);
    chk("rstmid_rready_held_low", 32'(M_AXI_RREADY), 32'h0);
    chk("rstmid_rsp_valid_low", 32'(rsp_valid), 32'h0);
    @(negedge ACLK) ARESETN = 1'b1;
    r_wait = 0;
    repeat (5) @(negedge ACLK);
    chk("rstmid_no_response", 32'(rsp_cnt - rc), 32'h0);
    @(posedge ACLK); #1;
    t_addr[0] = REG0; t_addr[1] = REG1; req_write = '0; req_valid = 2'b11;
    @(negedge ACLK);
    chk("rstmid_first_grant_req0", 32'(req_ready), 32'h1);
    @(posedge ACLK); #1 req_valid = '0;
    repeat (6) @(posedge ACLK); #1;

`ifdef MAN_INPUT_ARB_TIMEOUT_EN
    // Slave never answers B: SLVERR after 16 WR_RESP cycles, sticky flag set.
    no_b = 1'b1;
    issue(1'b0, 1'b1, REG2, 32'h0000_0077, rd, rr, lat, stray, ok);
    chk("tmo_done", 32'(ok), 32'h1);
    chk("tmo_resp", 32'(rr), 32'(RESP_SLVERR));
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_latency", 32'(lat), 32'd18);
    @(negedge ACLK);
    chk("tmo_flag", 32'(timeout_flag), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
